control_unit_mp: RTL

- Byte-stream command decoder between the host serial/SPI byte receiver and N parallel DSP pipelines. Next generation of the pipeline control unit.
- Command byte carries an opcode and an explicit pipeline index, not a single pipeline-select bit.
- Operand field widths are parametrised.
- Adds operand/handshake timeouts, a pipeline-index range check and a busy flag.

---
 rtl/control_unit_mp.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit_mp.sv
// control_unit_mp: byte-stream command decoder driving N DSP pipelines.
// Define CONTROL_UNIT_CHECKSUM_EN to require a trailing XOR checksum byte.
module control_unit_mp #(
  parameter int N_PIPELINES    = 2,
  parameter int N_BLOCKS       = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int INSTR_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int BW = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_byte,
  input  logic                      in_ready,
  output logic                      next,
  output logic [BW-1:0]             block_target,
  output logic [REG_ADDR_WIDTH-1:0] reg_target,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic [INSTR_WIDTH-1:0]    instr_out,
  output logic [N_PIPELINES-1:0]    block_instr_write,
  output logic [N_PIPELINES-1:0]    block_reg_write,
  input  logic [N_PIPELINES-1:0]    reg_write_ack,
  output logic [N_PIPELINES-1:0]    block_reg_update,
  output logic [N_PIPELINES-1:0]    alloc_sram_delay,
  output logic [N_PIPELINES-1:0]    reset_pipeline,
  output logic                      swap_pipelines,
  input  logic                      pipelines_swapping,
  output logic                      set_input_gain,
  output logic                      set_output_gain,
  output logic                      busy,
  output logic                      invalid,
  output logic                      timeout
);

  localparam int DB = DATA_WIDTH / 8;
  localparam int IB = INSTR_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] OP_WI = 4'd1;
  localparam logic [3:0] OP_WR = 4'd2;
  localparam logic [3:0] OP_UR = 4'd3;
  localparam logic [3:0] OP_AD = 4'd4;
  localparam logic [3:0] OP_SW = 4'd5;
  localparam logic [3:0] OP_RP = 4'd6;
  localparam logic [3:0] OP_IG = 4'd7;
  localparam logic [3:0] OP_OG = 4'd8;

  typedef enum logic [3:0] {
    S_READY,
    S_DECODE,
    S_BLOCK,
    S_REG,
    S_DATA,
    S_INSTR,
`ifdef CONTROL_UNIT_CHECKSUM_EN
    S_CSUM,
`endif
    S_EXEC,
    S_REG_WAIT,
    S_SWAP_RISE,
    S_SWAP_FALL
  } state_t;

`ifdef CONTROL_UNIT_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_EXEC;
`endif

  state_t                    state_q, state_d;
  logic [7:0]                cmd_q, cmd_d;
  logic [BW-1:0]             block_q, block_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic [3:0]                bcnt_q, bcnt_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      guard_q, guard_d;
`ifdef CONTROL_UNIT_CHECKSUM_EN
  logic [7:0]                csum_q, csum_d;
`endif

  logic [3:0]             op;
  logic [3:0]             p;
  logic [N_PIPELINES-1:0] p_sel;
  logic                   p_ok;
  logic                   accept_st;
  logic                   wait_st;
  logic                   consume;
  logic                   to_hit;
  logic                   ack_p;

  assign op = cmd_q[7:4];
  assign p  = cmd_q[3:0];
  assign p_ok = {28'd0, p} < 32'(N_PIPELINES);

  always_comb begin
    for (int i = 0; i < N_PIPELINES; i++) begin
      p_sel[i] = (p == 4'(i));
    end
  end

  assign accept_st = (state_q == S_READY) || (state_q == S_BLOCK) ||
                     (state_q == S_REG)   || (state_q == S_DATA)  ||
`ifdef CONTROL_UNIT_CHECKSUM_EN
                     (state_q == S_CSUM)  ||
`endif
                     (state_q == S_INSTR);
  assign wait_st = (accept_st && state_q != S_READY) ||
                   (state_q == S_REG_WAIT) ||
                   (state_q == S_SWAP_RISE) ||
                   (state_q == S_SWAP_FALL);
  assign consume = !reset && accept_st && in_ready && !guard_q;
  assign to_hit  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  // cnt_q is zero only in the first REG_WAIT cycle, where ack is ignored
  assign ack_p   = |(reg_write_ack & p_sel) && (cnt_q != '0);
  assign next    = consume;
  assign busy    = (state_q != S_READY);
  assign block_target = block_q;
  assign reg_target   = reg_q;
  assign data_out     = data_q;
  assign instr_out    = instr_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    block_d = block_q;
    reg_d   = reg_q;
    data_d  = data_q;
    instr_d = instr_q;
    bcnt_d  = bcnt_q;
    guard_d = consume;
    block_instr_write = '0;
    block_reg_write   = '0;
    block_reg_update  = '0;
    alloc_sram_delay  = '0;
    reset_pipeline    = '0;
    swap_pipelines    = 1'b0;
    set_input_gain    = 1'b0;
    set_output_gain   = 1'b0;
    invalid           = 1'b0;
    timeout           = 1'b0;
`ifdef CONTROL_UNIT_CHECKSUM_EN
    csum_d = csum_q;
    if (consume) begin
      csum_d = (state_q == S_READY) ? in_byte : (csum_q ^ in_byte);
    end
`endif

    unique case (state_q)
      S_READY: begin
        if (consume) begin
          cmd_d   = in_byte;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        bcnt_d  = '0;
        state_d = S_READY;
        unique case (op)
          OP_WI, OP_WR, OP_UR: begin
            if (p_ok) state_d = S_BLOCK;
            else invalid = 1'b1;
          end
          OP_AD: begin
            if (p_ok) state_d = S_DATA;
            else invalid = 1'b1;
          end
          OP_RP: begin
            if (p_ok) state_d = S_FIN;
            else invalid = 1'b1;
          end
          OP_SW:        state_d = S_FIN;
          OP_IG, OP_OG: state_d = S_DATA;
          default:      invalid = 1'b1;
        endcase
      end
      S_BLOCK: begin
        if (consume) begin
          block_d = in_byte[BW-1:0];
          state_d = (op == OP_WI) ? S_INSTR : S_REG;
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = S_READY;
        end
      end
      S_REG: begin
        if (consume) begin
          reg_d   = in_byte[REG_ADDR_WIDTH-1:0];
          state_d = S_DATA;
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = S_READY;
        end
      end
      S_DATA: begin
        if (consume) begin
          data_d = (data_q << 8) | DATA_WIDTH'(in_byte);
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'(DB - 1)) begin
            bcnt_d  = '0;
            state_d = S_FIN;
          end
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = S_READY;
        end
      end
      S_INSTR: begin
        if (consume) begin
          instr_d = (instr_q << 8) | INSTR_WIDTH'(in_byte);
          bcnt_d  = bcnt_q + 4'd1;
          if (bcnt_q == 4'(IB - 1)) begin
            bcnt_d  = '0;
            state_d = S_FIN;
          end
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = S_READY;
        end
      end
`ifdef CONTROL_UNIT_CHECKSUM_EN
      S_CSUM: begin
        if (consume) begin
          if (in_byte == csum_q) begin
            state_d = S_EXEC;
          end else begin
            invalid = 1'b1;
            state_d = S_READY;
          end
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = S_READY;
        end
      end
`endif
      S_EXEC: begin
        state_d = S_READY;
        unique case (op)
          OP_WI: block_instr_write = p_sel;
          OP_WR: begin
            block_reg_write = p_sel;
            state_d         = S_REG_WAIT;
          end
          OP_UR: block_reg_update = p_sel;
          OP_AD: alloc_sram_delay = p_sel;
          OP_SW: begin
            swap_pipelines = 1'b1;
            state_d        = S_SWAP_RISE;
          end
          OP_RP: reset_pipeline  = p_sel;
          OP_IG: set_input_gain  = 1'b1;
          OP_OG: set_output_gain = 1'b1;
          default: ;
        endcase
      end
      S_REG_WAIT: begin
        block_reg_write = p_sel;
        if (ack_p) begin
          state_d = S_READY;
        end else if (to_hit) begin
          block_reg_write = '0;
          timeout         = 1'b1;
          state_d         = S_READY;
        end
      end
      S_SWAP_RISE: begin
        if (pipelines_swapping) begin
          state_d = S_SWAP_FALL;
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = S_READY;
        end
      end
      S_SWAP_FALL: begin
        if (!pipelines_swapping) begin
          state_d = S_READY;
        end else if (to_hit) begin
          timeout = 1'b1;
          state_d = S_READY;
        end
      end
      default: state_d = S_READY;
    endcase

    if (consume || state_d != state_q) cnt_d = '0;
    else if (wait_st)                  cnt_d = cnt_q + 1'b1;
    else                               cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_READY;
      cmd_q   <= '0;
      block_q <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      instr_q <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      guard_q <= 1'b0;
`ifdef CONTROL_UNIT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      block_q <= block_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      instr_q <= instr_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
`ifdef CONTROL_UNIT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
